audio_tone_sequencer: RTL



---
 rtl/audio_pkg.sv | 47 ++++
 rtl/tone_square_gen.sv | 37 +++
 rtl/audio_tone_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the tone sequencer: note codes, FSM encoding,
// note frequency table and the half-period helper.
package audio_pkg;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_C4   = 4'd1;
    localparam logic [3:0] NOTE_CS4  = 4'd2;
    localparam logic [3:0] NOTE_D4   = 4'd3;
    localparam logic [3:0] NOTE_DS4  = 4'd4;
    localparam logic [3:0] NOTE_E4   = 4'd5;
    localparam logic [3:0] NOTE_F4   = 4'd6;
    localparam logic [3:0] NOTE_FS4  = 4'd7;
    localparam logic [3:0] NOTE_G4   = 4'd8;
    localparam logic [3:0] NOTE_GS4  = 4'd9;
    localparam logic [3:0] NOTE_A4   = 4'd10;
    localparam logic [3:0] NOTE_AS4  = 4'd11;
    localparam logic [3:0] NOTE_B4   = 4'd12;

    // Wide enough for C4 at 40 MHz (76335 cycles)
    localparam int PHASE_W = 18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOTE = 2'd1,
        ST_GAP  = 2'd2
    } seq_state_t;

    // Frequencies in Hz, entry 0 = C4 .. entry 11 = B4
    localparam int NOTE_FREQ [12] = '{262, 277, 294, 311, 330, 349,
                                      370, 392, 415, 440, 466, 494};

    function automatic logic is_tone(input logic [3:0] code);
        return (code >= NOTE_C4) && (code <= NOTE_B4);
    endfunction

    // Clock cycles per half wave; rests get 1 so a reload never underflows
    function automatic logic [PHASE_W-1:0] half_period(input logic [3:0] code,
                                                       input int clk_hz);
        int idx;
        idx = int'(code) - 1;
        if (is_tone(code))
            return PHASE_W'(clk_hz / (2 * NOTE_FREQ[idx]));
        else
            return PHASE_W'(1);
    endfunction

endpackage

// File: rtl/tone_square_gen.sv
// Square-wave generator: phase counter reloads every half period and
// toggles the wave bit; holds while disabled (rests, gaps, idle).
module tone_square_gen
    import audio_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_enable,
    input  logic [PHASE_W-1:0] i_hp,
    output logic               o_wave
);

    logic [PHASE_W-1:0] r_phase;
    logic               r_wave;

    // Load starts a note on the high half; otherwise count down and toggle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= '0;
            r_wave  <= 1'b0;
        end else if (i_load) begin
            r_phase <= i_hp - 1'b1;
            r_wave  <= 1'b1;
        end else if (i_enable) begin
            if (r_phase == '0) begin
                r_phase <= i_hp - 1'b1;
                r_wave  <= ~r_wave;
            end else begin
                r_phase <= r_phase - 1'b1;
            end
        end
    end

    assign o_wave = r_wave;

endmodule

// File: rtl/audio_tone_sequencer.sv
// Plays up to 8 programmed notes as square-wave PCM, updating the sample
// only on serialiser frame boundaries (audio_ws rising edge).
// Optional macro TONE_SEQ_VOLUME_EN adds a 2-bit vol input that shifts
// the amplitude right arithmetically.
module audio_tone_sequencer
    import audio_pkg::*;
#(
    parameter int          CLK_HZ          = 40_000_000,
    parameter int          NOTE_DUR_CYCLES = 10_000_000,
    parameter int          GAP_CYCLES      = 400_000,
    parameter logic [15:0] AMPLITUDE       = 16'h4000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        audio_ws,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [3:0]  wr_note,
    input  logic [2:0]  seq_last,
    input  logic        loop,
    input  logic        start,
    input  logic        stop,
`ifdef TONE_SEQ_VOLUME_EN
    input  logic [1:0]  vol,
`endif
    output logic [15:0] audio_left,
    output logic [15:0] audio_right,
    output logic        busy,
    output logic [2:0]  note_idx,
    output logic        done
);

    localparam int DUR_W = (NOTE_DUR_CYCLES > 1) ? $clog2(NOTE_DUR_CYCLES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DUR_W-1:0] DUR_MAX = DUR_W'(NOTE_DUR_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES - 1);

    seq_state_t         r_state, w_state_nxt;
    logic [3:0]         r_tab [8];
    logic [2:0]         r_idx;
    logic [3:0]         r_note;
    logic [DUR_W-1:0]   r_dur;
    logic [GAP_W-1:0]   r_gap;
    logic               r_ws_q;
    logic [15:0]        r_audio;
    logic               r_done;

    logic               w_load;
    logic [2:0]         w_load_idx;
    logic               w_done_nxt;
    logic               w_wave;
    logic               w_tone;
    logic [PHASE_W-1:0] w_hp;
    logic [PHASE_W-1:0] w_hp_tab [16];
    logic [15:0]        w_amp;
    logic [15:0]        w_target;

    // Half periods are elaboration-time constants per note code
    for (genvar c = 0; c < 16; c++) begin : g_hp
        assign w_hp_tab[c] = half_period(4'(c), CLK_HZ);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state; stop beats everything, including a same-cycle start
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_idx  = r_idx;
        w_done_nxt  = 1'b0;
        if (stop) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    w_state_nxt = ST_NOTE;
                    w_load      = 1'b1;
                    w_load_idx  = 3'd0;
                end
                ST_NOTE: if (r_dur == '0) w_state_nxt = ST_GAP;
                ST_GAP: if (r_gap == '0) begin
                    if (r_idx < seq_last) begin
                        w_state_nxt = ST_NOTE;
                        w_load      = 1'b1;
                        w_load_idx  = r_idx + 3'd1;
                    end else if (loop) begin
                        w_state_nxt = ST_NOTE;
                        w_load      = 1'b1;
                        w_load_idx  = 3'd0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Note table, note load and duration/gap counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) r_tab[i] <= NOTE_REST;
            r_idx  <= '0;
            r_note <= NOTE_REST;
            r_dur  <= '0;
            r_gap  <= '0;
            r_done <= 1'b0;
        end else begin
            if (wr_en) r_tab[wr_addr] <= wr_note;
            r_done <= w_done_nxt;
            if (w_load) begin
                r_idx  <= w_load_idx;
                r_note <= r_tab[w_load_idx];
                r_dur  <= DUR_MAX;
            end else if (r_state == ST_NOTE) begin
                r_dur <= r_dur - 1'b1;
                if (r_dur == '0) r_gap <= GAP_MAX;
            end else if (r_state == ST_GAP) begin
                r_gap <= r_gap - 1'b1;
            end
        end
    end

    assign w_tone = is_tone(r_note);
    // On a load the table entry being loaded supplies the period
    assign w_hp   = w_load ? w_hp_tab[r_tab[w_load_idx]] : w_hp_tab[r_note];

    tone_square_gen u_sq (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_enable ((r_state == ST_NOTE) && w_tone),
        .i_hp     (w_hp),
        .o_wave   (w_wave)
    );

`ifdef TONE_SEQ_VOLUME_EN
    assign w_amp = 16'($signed(AMPLITUDE) >>> vol);
`else
    assign w_amp = AMPLITUDE;
`endif

    assign w_target = ((r_state == ST_NOTE) && w_tone)
                      ? (w_wave ? w_amp : 16'(16'd0 - w_amp))
                      : 16'd0;

    // Sample register updates only on a word-select rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ws_q  <= 1'b0;
            r_audio <= '0;
        end else begin
            r_ws_q <= audio_ws;
            if (audio_ws && !r_ws_q) r_audio <= w_target;
        end
    end

    assign audio_left  = r_audio;
    assign audio_right = r_audio;
    assign busy        = (r_state != ST_IDLE);
    assign note_idx    = r_idx;
    assign done        = r_done;

endmodule
